// File: rtl/seq_div4_unit_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master side (ALU controller) drives E/START/Ain/Bin; the slave side
// (the divider) returns Q/R/BUSY/DONE/DZ.
interface seq_div4_unit_if #(
    parameter int WIDTH = 4
);
    logic             E;
    logic             START;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             BUSY;
    logic             DONE;
    logic             DZ;

    modport master (
        output E, START, Ain, Bin,
        input  Q, R, BUSY, DONE, DZ
    );

    modport slave (
        input  E, START, Ain, Bin,
        output Q, R, BUSY, DONE, DZ
    );
endinterface

// File: rtl/seq_div4_unit.sv
// Multi-cycle restoring divider: one quotient bit per enabled clock, with a
// START/BUSY/DONE handshake. Divide-by-zero skips the iteration and reports
// Q=all ones, R=Ain, DZ=1.
// Optional macro SEQ_DIV_SIGNED_EN: two's complement operands; magnitudes run
// through the same unsigned core and signs are fixed on the FIN load.
module seq_div4_unit #(
    parameter int WIDTH = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    seq_div4_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SEQ_DIV_SIGNED_EN
    function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] neg_v;
        neg_v = -v;
        return v[WIDTH-1] ? $unsigned(neg_v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic neg);
        logic signed [WIDTH-1:0] s;
        logic signed [WIDTH-1:0] neg_s;
        s     = $signed(mag);
        neg_s = -s;
        return neg ? $unsigned(neg_s) : mag;
    endfunction
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SEQ_DIV_SIGNED_EN
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
`endif

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dvd_nx;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // One restoring step plus operand magnitude and final result shaping.
    always_comb begin
        // Since rem_q < divisor, the shifted remainder is below 2*divisor, so a
        // WIDTH+1-bit difference has its top bit set exactly when it borrows.
        rem_sh    = {rem_q, dvd_q[WIDTH-1]};
        trial     = rem_sh - {1'b0, dvs_q};
        no_borrow = ~trial[WIDTH];
        rem_nx    = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_nx    = {dvd_q[WIDTH-2:0], no_borrow};
`ifdef SEQ_DIV_SIGNED_EN
        a_mag = mag_of(bus.Ain);
        b_mag = mag_of(bus.Bin);
        q_fin = apply_sign(dvd_nx, neg_q_q);
        r_fin = apply_sign(rem_nx, neg_r_q);
`else
        a_mag = bus.Ain;
        b_mag = bus.Bin;
        q_fin = dvd_nx;
        r_fin = rem_nx;
`endif
    end

    // Control FSM: accept in IDLE, iterate in RUN, present result in FIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef SEQ_DIV_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (bus.E && bus.START) begin
                    dvd_d  = a_mag;
                    dvs_d  = b_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
                    neg_q_d = bus.Ain[WIDTH-1] ^ bus.Bin[WIDTH-1];
                    neg_r_d = bus.Ain[WIDTH-1];
`endif
                    if (bus.Bin == '0) begin
                        // Divide by zero: result is known now, go straight to FIN.
                        q_d     = '1;
                        r_d     = bus.Ain;
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.E) begin
                    rem_d = rem_nx;
                    dvd_d = dvd_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        q_d     = q_fin;
                        r_d     = r_fin;
                        dz_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                if (bus.E) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset clearing everything.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.DZ   = dz_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule
